// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, write-controller state type and sizing helpers.
package sdram_pkg;

    typedef logic [3:0] cmd_t;  // {CS_n, RAS_n, CAS_n, WE_n}

    localparam cmd_t CMD_NOP    = 4'b0111;
    localparam cmd_t CMD_ACTIVE = 4'b0011;
    localparam cmd_t CMD_WRITE  = 4'b0100;
    localparam cmd_t CMD_BST    = 4'b0110;
    localparam cmd_t CMD_PRE    = 4'b0010;

    // A10 selects auto-precharge on WRITE and all-banks on PRECHARGE
    localparam int A10_BIT = 10;

    typedef enum logic [3:0] {
        S_IDLE, S_ACT, S_TRCD_W, S_WR, S_BST, S_TWR_W, S_PRE, S_TRP_W, S_END
    } wr_state_t;

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to hold the value n (at least one)
    function automatic int cnt_w(int n);
        int w;
        w = 1;
        while ((1 << w) <= n) w++;
        return w;
    endfunction

endpackage

// File: rtl/sdram_wr_burst_ctrl_if.sv
// Request/data/pin bundle between the arbiter side and the SDRAM write controller.
interface sdram_wr_burst_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int BA_W   = 2,
    parameter int ROW_W  = 13,
    parameter int COL_W  = 9,
    parameter int BL_W   = 10
);
    localparam int AW = BA_W + ROW_W + COL_W;

    logic              init_end_i;
    logic              wr_en_i;
    logic [AW-1:0]     wr_addr_i;
    logic [BL_W-1:0]   wr_burst_len_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              wr_ack_o;
    logic              wr_end_o;
    logic [3:0]        wr_cmd_o;
    logic [BA_W-1:0]   wr_ba_o;
    logic [ROW_W-1:0]  wr_addr_o;
    logic              wr_sdram_en_o;
    logic [DATA_W-1:0] wr_sdram_data_o;

    modport master (
        output init_end_i, wr_en_i, wr_addr_i, wr_burst_len_i, wr_data_i,
        input  wr_ack_o, wr_end_o, wr_cmd_o, wr_ba_o, wr_addr_o,
               wr_sdram_en_o, wr_sdram_data_o
    );

    modport slave (
        input  init_end_i, wr_en_i, wr_addr_i, wr_burst_len_i, wr_data_i,
        output wr_ack_o, wr_end_o, wr_cmd_o, wr_ba_o, wr_addr_o,
               wr_sdram_en_o, wr_sdram_data_o
    );
endinterface

// File: rtl/sdram_addr_cnt.sv
// Flat {ba,row,col} beat address counter; carries ripple col->row->bank->0 naturally.
module sdram_addr_cnt #(
    parameter int BA_W  = 2,
    parameter int ROW_W = 13,
    parameter int COL_W = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic                         inc,
    input  logic [BA_W+ROW_W+COL_W-1:0]  load_addr,
    output logic [BA_W-1:0]              ba,
    output logic [ROW_W-1:0]             row,
    output logic [COL_W-1:0]             col,
    output logic                         page_last
);
    localparam int AW = BA_W + ROW_W + COL_W;

    logic [AW-1:0] addr;

    always_ff @(posedge clk) begin
        if (rst)       addr <= '0;
        else if (load) addr <= load_addr;
        else if (inc)  addr <= addr + 1'b1;
    end

    assign ba        = addr[AW-1 -: BA_W];
    assign row       = addr[COL_W +: ROW_W];
    assign col       = addr[COL_W-1:0];
    assign page_last = &col;
endmodule

// File: rtl/sdram_wr_burst_ctrl.sv
// SDRAM write-burst controller: ACTIVE/WRITE/BURST_STOP/PRECHARGE per page segment,
// splitting bursts that cross a page by closing and reopening the next row.
module sdram_wr_burst_ctrl
    import sdram_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int BA_W   = 2,
    parameter int ROW_W  = 13,
    parameter int COL_W  = 9,
    parameter int BL_W   = 10,
    parameter int TRCD   = 2,
    parameter int TWR    = 2,
    parameter int TRP    = 2
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    sdram_wr_burst_ctrl_if.slave  bus
);
    localparam int AW = BA_W + ROW_W + COL_W;
    localparam int TW = cnt_w(max3(TRCD, TWR, TRP));
    localparam logic [ROW_W-1:0] PRE_ADDR = ROW_W'(1) << A10_BIT;

    wr_state_t         state;
    logic [TW-1:0]     tcnt;
    logic [BL_W-1:0]   rem;
    cmd_t              cmd;
    logic [BA_W-1:0]   ba;
    logic [ROW_W-1:0]  addr;
    logic              sd_en;
    logic [DATA_W-1:0] sd_data;
    logic              wr_end;

    logic [BA_W-1:0]   cnt_ba;
    logic [ROW_W-1:0]  cnt_row;
    logic [COL_W-1:0]  cnt_col;
    logic              page_last;
    logic [ROW_W-1:0]  col_addr;

    logic accept, beat, seg_last, trcd_done, twr_done, trp_done, ack;

    assign accept    = (state == S_IDLE) && bus.init_end_i && bus.wr_en_i &&
                       (bus.wr_burst_len_i != '0);
    assign beat      = (state == S_WR);
    assign seg_last  = (rem == BL_W'(1)) || page_last;
    assign trcd_done = ((state == S_ACT) && (TRCD == 1)) ||
                       ((state == S_TRCD_W) && (tcnt == '0));
    // BURST_STOP always takes the cycle after the last beat, so TWR below 2 cannot be shortened further
    assign twr_done  = ((state == S_BST) && (TWR <= 2)) ||
                       ((state == S_TWR_W) && (tcnt == '0));
    assign trp_done  = ((state == S_PRE) && (TRP == 1)) ||
                       ((state == S_TRP_W) && (tcnt == '0));

    // Pop strobe leads each beat by one cycle: the cycle before WR, then every WR cycle but the segment's last
    assign ack = trcd_done || (beat && !seg_last);

    always_comb begin
        col_addr = '0;
        col_addr[COL_W-1:0] = cnt_col;
        col_addr[A10_BIT] = 1'b0;
    end

    sdram_addr_cnt #(.BA_W(BA_W), .ROW_W(ROW_W), .COL_W(COL_W)) u_addr_cnt (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .load      (accept),
        .inc       (beat),
        .load_addr (bus.wr_addr_i),
        .ba        (cnt_ba),
        .row       (cnt_row),
        .col       (cnt_col),
        .page_last (page_last)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state   <= S_IDLE;
            tcnt    <= '0;
            rem     <= '0;
            cmd     <= CMD_NOP;
            ba      <= '0;
            addr    <= '0;
            sd_en   <= 1'b0;
            sd_data <= '0;
            wr_end  <= 1'b0;
        end else begin
            cmd    <= CMD_NOP;
            wr_end <= 1'b0;
            sd_en  <= ack;
            if (ack)  sd_data <= bus.wr_data_i;
            if (beat) rem <= rem - 1'b1;

            case (state)
                S_IDLE: if (accept) begin
                    rem   <= bus.wr_burst_len_i;
                    state <= S_ACT;
                    cmd   <= CMD_ACTIVE;
                    ba    <= bus.wr_addr_i[AW-1 -: BA_W];
                    addr  <= bus.wr_addr_i[COL_W +: ROW_W];
                end
                S_ACT, S_TRCD_W: begin
                    if (trcd_done) begin
                        state <= S_WR;
                        cmd   <= CMD_WRITE;
                        addr  <= col_addr;
                    end else if (state == S_ACT) begin
                        state <= S_TRCD_W;
                        tcnt  <= TW'(TRCD - 2);
                    end else begin
                        tcnt  <= tcnt - 1'b1;
                    end
                end
                S_WR: if (seg_last) begin
                    state <= S_BST;
                    cmd   <= CMD_BST;
                end
                S_BST, S_TWR_W: begin
                    if (twr_done) begin
                        state <= S_PRE;
                        cmd   <= CMD_PRE;
                        addr  <= PRE_ADDR;
                    end else if (state == S_BST) begin
                        state <= S_TWR_W;
                        tcnt  <= TW'(TWR - 3);
                    end else begin
                        tcnt  <= tcnt - 1'b1;
                    end
                end
                S_PRE, S_TRP_W: begin
                    if (trp_done) begin
                        // Counter already points at col 0 of the next row when a page split remains
                        if (rem != '0) begin
                            state <= S_ACT;
                            cmd   <= CMD_ACTIVE;
                            ba    <= cnt_ba;
                            addr  <= cnt_row;
                        end else begin
                            state  <= S_END;
                            wr_end <= 1'b1;
                        end
                    end else if (state == S_PRE) begin
                        state <= S_TRP_W;
                        tcnt  <= TW'(TRP - 2);
                    end else begin
                        tcnt  <= tcnt - 1'b1;
                    end
                end
                S_END:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.wr_ack_o        = ack;
    assign bus.wr_end_o        = wr_end;
    assign bus.wr_cmd_o        = cmd;
    assign bus.wr_ba_o         = ba;
    assign bus.wr_addr_o       = addr;
    assign bus.wr_sdram_en_o   = sd_en;
    assign bus.wr_sdram_data_o = sd_data;
endmodule

// File: tb/tb_sdram_wr_burst_ctrl.sv
// Bench for sdram_wr_burst_ctrl: table vectors, corner sequences and random requests
// compared cycle by cycle against a segment-level timing model.
module tb_sdram_wr_burst_ctrl;
    import sdram_pkg::*;

    localparam int DATA_W = 16, BA_W = 2, ROW_W = 13, COL_W = 9, BL_W = 10;
    localparam int TRCD = 2, TWR = 2, TRP = 2;
    localparam int AW = BA_W + ROW_W + COL_W;
    localparam int PAGE = 1 << COL_W;
    localparam int MAXC = 1024;
    localparam int DM = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdram_wr_burst_ctrl_if #(.DATA_W(DATA_W), .BA_W(BA_W), .ROW_W(ROW_W),
                             .COL_W(COL_W), .BL_W(BL_W)) bus();

    sdram_wr_burst_ctrl #(.DATA_W(DATA_W), .BA_W(BA_W), .ROW_W(ROW_W), .COL_W(COL_W),
                          .BL_W(BL_W), .TRCD(TRCD), .TWR(TWR), .TRP(TRP)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    int idx = 0;
    logic [DATA_W-1:0] dmem [DM];

    cmd_t              e_cmd  [MAXC];
    logic [BA_W-1:0]   e_ba   [MAXC];
    logic [ROW_W-1:0]  e_addr [MAXC];
    int                e_kind [MAXC];  // 1 ACTIVE, 2 WRITE, 3 PRECHARGE
    bit                e_en   [MAXC];
    bit                e_ack  [MAXC];
    bit                e_end  [MAXC];
    logic [DATA_W-1:0] e_data [MAXC];

    cmd_t              r_cmd  [MAXC];
    logic [BA_W-1:0]   r_ba   [MAXC];
    logic [ROW_W-1:0]  r_addr [MAXC];
    logic              r_en   [MAXC];
    logic              r_ack  [MAXC];
    logic              r_end  [MAXC];
    logic [DATA_W-1:0] r_data [MAXC];

    typedef struct {
        logic [AW-1:0]    addr;
        int               len;
        bit               init;
        int               exp_end;
        int               exp_beats;
        int               exp_acts;
        logic [BA_W-1:0]  exp_ba;
        logic [ROW_W-1:0] exp_row;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [AW-1:0] mk(int b, int r, int c);
        return {BA_W'(b), ROW_W'(r), COL_W'(c)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_exp();
        for (int k = 0; k < MAXC; k++) begin
            e_cmd[k] = CMD_NOP; e_ba[k] = '0; e_addr[k] = '0; e_kind[k] = 0;
            e_en[k] = 0; e_ack[k] = 0; e_end[k] = 0; e_data[k] = '0;
        end
    endtask

    // Request presented in cycle t0; walks page segments with plain arithmetic
    task automatic model_req(input int t0, input logic [AW-1:0] a0, input int len,
                             input int base, output int tend);
        int t, rem, k, col, n, w, last, pre;
        logic [AW-1:0] a;
        t = t0 + 1; rem = len; a = a0; k = 0;
        while (rem > 0) begin
            col = int'(a[COL_W-1:0]);
            n = (rem < PAGE - col) ? rem : PAGE - col;
            e_cmd[t] = CMD_ACTIVE; e_kind[t] = 1;
            e_ba[t] = a[AW-1 -: BA_W]; e_addr[t] = a[COL_W +: ROW_W];
            w = t + TRCD;
            e_cmd[w] = CMD_WRITE; e_kind[w] = 2; e_addr[w] = ROW_W'(col);
            for (int i = 0; i < n; i++) begin
                e_ack[w + i - 1] = 1;
                e_en[w + i] = 1;
                e_data[w + i] = dmem[(base + k) % DM];
                k++;
            end
            last = w + n - 1;
            e_cmd[last + 1] = CMD_BST;
            pre = last + ((TWR > 2) ? TWR : 2);
            e_cmd[pre] = CMD_PRE; e_kind[pre] = 3;
            a = a + AW'(n);
            rem -= n;
            t = pre + TRP;
        end
        e_end[t] = 1;
        tend = t;
    endtask

    // Sample cycle k away from the edge, then act as a read-ahead FIFO on the pop strobe
    task automatic cycle(input int k);
        @(negedge clk);
        r_cmd[k] = bus.wr_cmd_o; r_ba[k] = bus.wr_ba_o; r_addr[k] = bus.wr_addr_o;
        r_en[k] = bus.wr_sdram_en_o; r_ack[k] = bus.wr_ack_o; r_end[k] = bus.wr_end_o;
        r_data[k] = bus.wr_sdram_data_o;
        @(posedge clk);
        #1;
        if (r_ack[k] === 1'b1) begin
            idx++;
            bus.wr_data_i = dmem[idx % DM];
        end
    endtask

    task automatic compare(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s t%0d cmd/en/ack/end", tag, k),
                {r_cmd[k], r_en[k], r_ack[k], r_end[k]},
                {e_cmd[k], e_en[k], e_ack[k], e_end[k]});
            if (e_kind[k] == 1) begin
                chk($sformatf("%s t%0d act_ba", tag, k), r_ba[k], e_ba[k]);
                chk($sformatf("%s t%0d act_row", tag, k), r_addr[k], e_addr[k]);
            end else if (e_kind[k] == 2) begin
                chk($sformatf("%s t%0d wr_col", tag, k), r_addr[k], e_addr[k]);
            end else if (e_kind[k] == 3) begin
                chk($sformatf("%s t%0d pre_a10", tag, k), r_addr[k][A10_BIT], 1'b1);
            end
            if (e_en[k]) chk($sformatf("%s t%0d data", tag, k), r_data[k], e_data[k]);
        end
    endtask

    task automatic run_req(input logic [AW-1:0] a, input int len, input bit init,
                           input int hold, input string tag, output int tend, output int n);
        int base;
        clear_exp();
        base = idx;
        tend = -1;
        if (init && len != 0) model_req(0, a, len, base, tend);
        bus.init_end_i = init;
        bus.wr_addr_i = a;
        bus.wr_burst_len_i = BL_W'(len);
        bus.wr_en_i = 1'b1;
        n = (tend >= 0) ? tend + 4 : hold + 8;
        for (int k = 0; k < n; k++) begin
            if (k == hold) bus.wr_en_i = 1'b0;
            cycle(k);
        end
        bus.init_end_i = 1'b1;
        compare(n, tag);
    endtask

    initial begin
        int tend, n, t1, t2, base;
        int first_end, beats, acts, acks, ends, busy;
        logic [BA_W-1:0] lba;
        logic [ROW_W-1:0] lrow;
        logic [AW-1:0] ra;
        int rlen;

        for (int i = 0; i < DM; i++) dmem[i] = DATA_W'($urandom);
        bus.init_end_i = 1'b0; bus.wr_en_i = 1'b0; bus.wr_addr_i = '0;
        bus.wr_burst_len_i = '0; bus.wr_data_i = dmem[0];

        vecs[0] = '{mk(1, 16'h0005, 16'h010), 4, 1'b1, 10, 4, 1, 2'd1, 13'h0005};
        vecs[1] = '{mk(1, 16'h0005, 16'h1FE), 4, 1'b1, 15, 4, 2, 2'd1, 13'h0006};
        vecs[2] = '{mk(0, 16'h1FFF, 16'h1FF), 2, 1'b1, 13, 2, 2, 2'd1, 13'h0000};
        vecs[3] = '{mk(2, 16'h0007, 16'h020), 0, 1'b1, -1, 0, 0, 2'd0, 13'h0000};
        vecs[4] = '{mk(2, 16'h0007, 16'h020), 4, 1'b0, -1, 0, 0, 2'd0, 13'h0000};
        vecs[5] = '{mk(3, 16'h0100, 16'h000), 1, 1'b1, 7, 1, 1, 2'd3, 13'h0100};
        vecs[6] = '{mk(2, 16'h00AA, 16'h1FC), 4, 1'b1, 10, 4, 1, 2'd2, 13'h00AA};
        vecs[7] = '{mk(3, 16'h1FFF, 16'h1FF), 2, 1'b1, 13, 2, 2, 2'd0, 13'h0000};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset cmd", bus.wr_cmd_o, CMD_NOP);
        chk("reset outs", {bus.wr_ba_o, bus.wr_addr_o, bus.wr_sdram_data_o, bus.wr_sdram_en_o,
                           bus.wr_end_o, bus.wr_ack_o}, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.init_end_i = 1'b1;

        // Table vectors
        for (int v = 0; v < 8; v++) begin
            run_req(vecs[v].addr, vecs[v].len, vecs[v].init, 6, $sformatf("vec%0d", v), tend, n);
            first_end = -1; beats = 0; acts = 0; acks = 0; ends = 0; lba = '0; lrow = '0;
            for (int k = 0; k < n; k++) begin
                if (r_end[k] === 1'b1) begin ends++; if (first_end < 0) first_end = k; end
                if (r_en[k] === 1'b1) beats++;
                if (r_ack[k] === 1'b1) acks++;
                if (r_cmd[k] === CMD_ACTIVE) begin acts++; lba = r_ba[k]; lrow = r_addr[k]; end
            end
            chk($sformatf("vec%0d end_cycle", v), first_end, vecs[v].exp_end);
            chk($sformatf("vec%0d end_pulses", v), ends, (vecs[v].exp_end >= 0) ? 1 : 0);
            chk($sformatf("vec%0d beats", v), beats, vecs[v].exp_beats);
            chk($sformatf("vec%0d acks", v), acks, vecs[v].exp_beats);
            chk($sformatf("vec%0d actives", v), acts, vecs[v].exp_acts);
            if (vecs[v].exp_acts > 0)
                chk($sformatf("vec%0d last_act", v), {lba, lrow}, {vecs[v].exp_ba, vecs[v].exp_row});
        end

        // Reset on the second beat of a len-8 burst
        bus.wr_addr_i = mk(1, 16'h0020, 16'h040); bus.wr_burst_len_i = BL_W'(8);
        bus.wr_en_i = 1'b1;
        cycle(0);
        bus.wr_en_i = 1'b0;
        for (int k = 1; k < 4; k++) cycle(k);
        rst = 1'b1;
        cycle(4);
        rst = 1'b0;
        for (int k = 5; k < 16; k++) cycle(k);
        chk("rst second beat on pins", r_en[4], 1'b1);
        chk("rst next cmd", r_cmd[5], CMD_NOP);
        chk("rst next en", r_en[5], 1'b0);
        ends = 0; busy = 0;
        for (int k = 4; k < 16; k++) if (r_end[k] === 1'b1) ends++;
        for (int k = 5; k < 16; k++) if (r_cmd[k] !== CMD_NOP || r_en[k] !== 1'b0) busy++;
        chk("rst no end pulse", ends, 0);
        chk("rst stays idle", busy, 0);
        run_req(mk(0, 16'h0003, 16'h000), 1, 1'b1, 1, "post_rst", tend, n);
        ends = 0;
        for (int k = 0; k < n; k++) if (r_end[k] === 1'b1) ends++;
        chk("post_rst completes", ends, 1);

        // Back-to-back requests with wr_en held; second address changes mid-flight
        clear_exp();
        base = idx;
        model_req(0, mk(2, 16'h0011, 16'h1FF), 3, base, t1);
        model_req(t1 + 1, mk(1, 16'h0040, 16'h005), 5, base + 3, t2);
        bus.wr_addr_i = mk(2, 16'h0011, 16'h1FF); bus.wr_burst_len_i = BL_W'(3);
        bus.wr_en_i = 1'b1;
        cycle(0);
        bus.wr_addr_i = mk(1, 16'h0040, 16'h005); bus.wr_burst_len_i = BL_W'(5);
        for (int k = 1; k <= t1 + 1; k++) cycle(k);
        bus.wr_en_i = 1'b0;
        for (int k = t1 + 2; k < t2 + 4; k++) cycle(k);
        compare(t2 + 4, "b2b");
        ends = 0;
        for (int k = 0; k < t2 + 4; k++) if (r_end[k] === 1'b1) ends++;
        chk("b2b end pulses", ends, 2);
        chk("b2b second active", r_cmd[t1 + 2], CMD_ACTIVE);

        // Random requests against the model
        for (int it = 0; it < 40; it++) begin
            ra[AW-1 -: BA_W] = BA_W'($urandom_range(0, 3));
            ra[COL_W +: ROW_W] = ($urandom_range(0, 3) == 0) ? {ROW_W{1'b1}} : ROW_W'($urandom);
            ra[COL_W-1:0] = ($urandom_range(0, 1) == 1) ? COL_W'($urandom_range(PAGE - 8, PAGE - 1))
                                                        : COL_W'($urandom_range(0, PAGE - 1));
            rlen = ($urandom_range(0, 9) == 0) ? $urandom_range(300, 700) : $urandom_range(0, 20);
            run_req(ra, rlen, 1'b1, 1, $sformatf("rnd%0d", it), tend, n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
